pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 16 +
 rtl/pc_gen_npc_calc.sv | 61 ++++++
 rtl/pc_gen.sv | 87 ++++++++
 tb/tb_pc_gen.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared CPU package: next-PC opcodes and address defaults
package pc_gen_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ = 3'd0,
        NPC_BR  = 3'd1,
        NPC_J   = 3'd2,
        NPC_JR  = 3'd3
    } npc_op_e;

    localparam logic [31:0] PC_RESET_DEF = 32'h0000_3000;
    localparam logic [31:0] PC_EXC_DEF   = 32'h0000_4180;
    localparam logic [31:0] IMEM_LO_DEF  = 32'h0000_3000;
    localparam logic [31:0] IMEM_HI_DEF  = 32'h0000_6FFF;

endpackage

// File: rtl/pc_gen_npc_calc.sv
// rtl/pc_gen_npc_calc.sv - combinational next-PC candidates and priority select
module pc_gen_npc_calc
    import pc_gen_pkg::*;
#(
    parameter int unsigned          WIDTH      = 32,
    parameter logic [WIDTH-1:0]     EXC_VEC    = WIDTH'(PC_EXC_DEF),
    parameter bit                   ERET_PLUS4 = 1'b1
) (
    input  logic [WIDTH-1:0] f_pc,
    input  logic [WIDTH-1:0] d_pc,
    input  logic [25:0]      imm26,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] epc,
    input  logic [2:0]       npc_op,
    input  logic             need_b,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic             exc_req,
    input  logic             eret,
    input  logic             pend_valid,
    input  logic [WIDTH-1:0] pend_target,
    output logic [WIDTH-1:0] eret_target,
    output logic [WIDTH-1:0] next_pc
);

    logic [WIDTH-1:0] seq_pc;
    logic [WIDTH-1:0] br_pc;
    logic [WIDTH-1:0] jmp_pc;
    logic [WIDTH-1:0] redir_pc;

    assign seq_pc      = f_pc + WIDTH'(4);
    assign br_pc       = d_pc + WIDTH'(4) + ({{(WIDTH-16){imm26[15]}}, imm26[15:0]} << 2);
    assign jmp_pc      = {d_pc[WIDTH-1:28], imm26, 2'b00};
    assign eret_target = epc + {{(WIDTH-3){1'b0}}, ERET_PLUS4, 2'b00};

    always_comb begin
        redir_pc = seq_pc;
        case (npc_op)
            NPC_BR:  redir_pc = need_b ? br_pc : seq_pc;
            NPC_J:   redir_pc = jmp_pc;
            NPC_JR:  redir_pc = rs_data;
            default: redir_pc = seq_pc;
        endcase
    end

    // A pending redirect squashes D, so its npc_op never reaches the select.
    always_comb begin
        next_pc = f_pc;
        if (imem_ready) begin
            if (exc_req)
                next_pc = EXC_VEC;
            else if (eret)
                next_pc = eret_target;
            else if (pend_valid)
                next_pc = pend_target;
            else if (!stall)
                next_pc = redir_pc;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC register with exception/eret redirect and pending target
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(PC_RESET_DEF),
    parameter logic [WIDTH-1:0] EXC_VEC    = WIDTH'(PC_EXC_DEF),
    parameter bit               ERET_PLUS4 = 1'b1,
    parameter logic [WIDTH-1:0] IMEM_LO    = WIDTH'(IMEM_LO_DEF),
    parameter logic [WIDTH-1:0] IMEM_HI    = WIDTH'(IMEM_HI_DEF)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             imem_ready,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    input  logic [2:0]       npc_op,
    input  logic             need_b,
    input  logic [WIDTH-1:0] d_pc,
    input  logic [25:0]      imm26,
    input  logic [WIDTH-1:0] rs_data,
    output logic [WIDTH-1:0] f_pc,
    output logic             f_adel,
    output logic             redirect_pend
);

    logic             pend_valid;
    logic             pend_is_exc;
    logic [WIDTH-1:0] pend_target;
    logic [WIDTH-1:0] eret_target;
    logic [WIDTH-1:0] next_pc;
    logic             next_fault;

    pc_gen_npc_calc #(
        .WIDTH      (WIDTH),
        .EXC_VEC    (EXC_VEC),
        .ERET_PLUS4 (ERET_PLUS4)
    ) u_npc_calc (
        .f_pc        (f_pc),
        .d_pc        (d_pc),
        .imm26       (imm26),
        .rs_data     (rs_data),
        .epc         (epc),
        .npc_op      (npc_op),
        .need_b      (need_b),
        .stall       (stall),
        .imem_ready  (imem_ready),
        .exc_req     (exc_req),
        .eret        (eret),
        .pend_valid  (pend_valid),
        .pend_target (pend_target),
        .eret_target (eret_target),
        .next_pc     (next_pc)
    );

    assign next_fault = (next_pc[1:0] != 2'b00) || (next_pc < IMEM_LO) || (next_pc > IMEM_HI);

    // The pending slot only fills while imem stalls; a held exc is never replaced by eret.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc        <= RESET_PC;
            f_adel      <= 1'b0;
            pend_valid  <= 1'b0;
            pend_is_exc <= 1'b0;
            pend_target <= '0;
        end else begin
            f_pc   <= next_pc;
            f_adel <= next_fault;
            if (imem_ready) begin
                pend_valid <= 1'b0;
            end else if (exc_req) begin
                pend_valid  <= 1'b1;
                pend_is_exc <= 1'b1;
                pend_target <= EXC_VEC;
            end else if (eret && !(pend_valid && pend_is_exc)) begin
                pend_valid  <= 1'b1;
                pend_is_exc <= 1'b0;
                pend_target <= eret_target;
            end
        end
    end

    assign redirect_pend = pend_valid;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - scoreboard bench for pc_gen with a reference model
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        reset, stall, imem_ready, exc_req, eret, need_b;
    logic [31:0] epc, d_pc, rs_data;
    logic [2:0]  npc_op;
    logic [25:0] imm26;
    logic [31:0] f_pc;
    logic        f_adel, redirect_pend;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] pc;
        logic        adel;
        logic        pend;
    } exp_t;
    exp_t sb[$];

    // reference state: the PC after the coming edge and an optional held redirect
    logic [31:0] m_pc = 32'h3000;
    bit          m_has_pend = 0;
    bit          m_pend_exc = 0;
    logic [31:0] m_pend_pc = 0;

    pc_gen dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .imem_ready    (imem_ready),
        .exc_req       (exc_req),
        .eret          (eret),
        .epc           (epc),
        .npc_op        (npc_op),
        .need_b        (need_b),
        .d_pc          (d_pc),
        .imm26         (imm26),
        .rs_data       (rs_data),
        .f_pc          (f_pc),
        .f_adel        (f_adel),
        .redirect_pend (redirect_pend)
    );

    always #5 clk = ~clk;

    task automatic tick();
        logic [31:0] eret_pc;
        int          off;
        exp_t        e;
        eret_pc = epc + 32'd4;
        if (reset) begin
            m_pc = 32'h3000;
            m_has_pend = 0;
            m_pend_exc = 0;
        end else if (imem_ready) begin
            if (exc_req)         m_pc = 32'h4180;
            else if (eret)       m_pc = eret_pc;
            else if (m_has_pend) m_pc = m_pend_pc;
            else if (!stall) begin
                off = $signed(imm26[15:0]) * 4;
                if (npc_op == 3'd1 && need_b) m_pc = d_pc + 32'd4 + off;
                else if (npc_op == 3'd2)      m_pc = (d_pc & 32'hF000_0000) | (32'(imm26) * 4);
                else if (npc_op == 3'd3)      m_pc = rs_data;
                else                          m_pc = m_pc + 32'd4;
            end
            m_has_pend = 0;
        end else if (exc_req) begin
            m_has_pend = 1; m_pend_exc = 1; m_pend_pc = 32'h4180;
        end else if (eret && !(m_has_pend && m_pend_exc)) begin
            m_has_pend = 1; m_pend_exc = 0; m_pend_pc = eret_pc;
        end
        e.pc   = m_pc;
        e.adel = !reset && (m_pc % 4 != 0 || m_pc < 32'h3000 || m_pc > 32'h6FFF);
        e.pend = m_has_pend;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic quiet();
        reset = 0; stall = 0; imem_ready = 1; exc_req = 0; eret = 0; need_b = 0;
        npc_op = 3'd0; epc = 32'h3100; d_pc = 32'h3000; imm26 = 26'd0; rs_data = 32'h3000;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("f_pc", f_pc, e.pc);
                chk("f_adel", 32'(f_adel), 32'(e.adel));
                chk("redirect_pend", 32'(redirect_pend), 32'(e.pend));
            end
        end
    end

    initial begin : driver
        quiet();
        reset = 1;
        tick(); tick();
        reset = 0;
        repeat (3) tick();
        // taken branch with offset -4 lands back on d_pc; untaken is sequential
        d_pc = 32'h3010; imm26 = 26'h000FFFF; npc_op = 3'd1; need_b = 1; tick();
        need_b = 0; tick();
        quiet();
        stall = 1; exc_req = 1; eret = 1; tick();
        quiet();
        imem_ready = 0; eret = 1; epc = 32'h3100; tick(); tick();
        eret = 0; tick();
        imem_ready = 1; tick(); tick();
        imem_ready = 0; eret = 1; tick();
        eret = 0; exc_req = 1; tick();
        exc_req = 0; imem_ready = 1; tick();
        imem_ready = 0; exc_req = 1; tick();
        exc_req = 0; eret = 1; tick();
        eret = 0; imem_ready = 1; tick();
        quiet();
        npc_op = 3'd3; rs_data = 32'h3002; tick();
        rs_data = 32'h7000; tick();
        rs_data = 32'h2FFC; tick();
        rs_data = 32'h6FFC; tick();
        quiet();
        imem_ready = 0; eret = 1; tick();
        reset = 1; exc_req = 1; tick();
        quiet(); tick();
        // pending redirect with stall and a redirecting npc_op must still win
        imem_ready = 0; exc_req = 1; tick();
        exc_req = 0; imem_ready = 1; stall = 1; npc_op = 3'd2; imm26 = 26'h123; tick();
        quiet();
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 49) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            imem_ready = ($urandom_range(0, 3) != 0);
            exc_req    = ($urandom_range(0, 15) == 0);
            eret       = ($urandom_range(0, 9) == 0);
            npc_op     = 3'($urandom_range(0, 7));
            need_b     = 1'($urandom);
            epc        = 32'h3000 + ($urandom_range(0, 32'h3FFF) & ~32'h3);
            d_pc       = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 32'h3FFF) & ~32'h3);
            imm26      = 26'($urandom);
            rs_data    = ($urandom_range(0, 3) == 0) ? $urandom : 32'h2FF0 + $urandom_range(0, 32'h4020);
            tick();
        end
        quiet();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
